// File: rtl/debounce_pkg.sv
// Shared widths and parameter legality helpers for the debounce bank.
// Pure elaboration-time helpers; there is no logic, latency or flow control here.
package debounce_pkg;

  // A counter that has to hold 0..n-1 needs clog2(n) bits, but never fewer than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int n_ch, input int tick_div, input int stable_cnt);
    return (n_ch >= 1) && (tick_div >= 1) && (stable_cnt >= 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: a 2-flop synchroniser, then a stable-count filter that is paced by tick.
// out moves 2 clk + STABLE_CNT ticks after a clean step. The channel runs freely and has no flow control.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   STABLE_CNT = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in_bit,
  output logic out_bit,
  output logic rise_bit,
  output logic fall_bit
);

  localparam int unsigned     CW      = cnt_w(STABLE_CNT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CNT - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_out;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= RESET_VAL;
      r_s2   <= RESET_VAL;
      r_out  <= RESET_VAL;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= in_bit;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (tick) begin
        // Any sample that agrees with out restarts the count, so a bounce costs the full window.
        if (r_s2 == r_out) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_out  <= r_s2;
          r_cnt  <= '0;
          r_rise <= r_s2;
          r_fall <= ~r_s2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign out_bit  = r_out;
  assign rise_bit = r_rise;
  assign fall_bit = r_fall;

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debouncers that share one clock-enable prescaler (tick every TICK_DIV clk).
// Latency is 2 clk + 1..TICK_DIV clk + (STABLE_CNT-1)*TICK_DIV clk. There is no flow control.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   N_CH       = 4,
  parameter int   TICK_DIV   = 50000,
  parameter int   STABLE_CNT = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  localparam int unsigned   PW      = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  if (!params_ok(N_CH, TICK_DIV, STABLE_CNT)) begin : g_bad_params
    $error("debounce_bank: N_CH, TICK_DIV and STABLE_CNT must all be >= 1");
  end

  logic [PW-1:0] r_pre;
  logic          w_tick;

  // With TICK_DIV=1 the counter is pinned at 0 and the tick stays high.
  assign w_tick = (r_pre == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT(STABLE_CNT),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (w_tick),
      .in_bit  (in[g]),
      .out_bit (out[g]),
      .rise_bit(rise[g]),
      .fall_bit(fall[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank with two instances (reset level 0 and reset level 1) that share the same inputs.
// A reference model checks every cycle, and directed scenarios pin latency, pulse counts and reset behaviour.
module tb_debounce_bank;

  localparam int NCH = 2;
  localparam int TD  = 4;
  localparam int SC  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] in  = '0;
  logic [NCH-1:0] out0, rise0, fall0;
  logic [NCH-1:0] out1, rise1, fall1;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(NCH), .TICK_DIV(TD), .STABLE_CNT(SC), .RESET_VAL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in(in), .out(out0), .rise(rise0), .fall(fall0));
  debounce_bank #(.N_CH(NCH), .TICK_DIV(TD), .STABLE_CNT(SC), .RESET_VAL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in(in), .out(out1), .rise(rise1), .fall(fall1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Reference model. The sample history is the input seen at each edge. A tick happens
  // on every TD-th edge after reset. out follows the synchronised level once that level
  // has disagreed with out on SC consecutive ticks.
  int             m_cyc;
  logic [NCH-1:0] m_s1[2], m_s2[2], m_out[2], m_rise[2], m_fall[2];
  int             m_run[2][NCH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0;
      for (int d = 0; d < 2; d++) begin
        m_s1[d]   = {NCH{d == 1}};
        m_s2[d]   = {NCH{d == 1}};
        m_out[d]  = {NCH{d == 1}};
        m_rise[d] = '0;
        m_fall[d] = '0;
        for (int c = 0; c < NCH; c++) m_run[d][c] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_rise[d] = '0;
        m_fall[d] = '0;
        if ((m_cyc % TD) == TD - 1) begin
          for (int c = 0; c < NCH; c++) begin
            if (m_s2[d][c] == m_out[d][c]) begin
              m_run[d][c] = 0;
            end else begin
              m_run[d][c] = m_run[d][c] + 1;
              if (m_run[d][c] == SC) begin
                m_out[d][c]  = m_s2[d][c];
                m_rise[d][c] = m_s2[d][c];
                m_fall[d][c] = ~m_s2[d][c];
                m_run[d][c]  = 0;
              end
            end
          end
        end
        m_s2[d] = m_s1[d];
        m_s1[d] = in;
      end
      m_cyc++;
    end
  end

  bit started = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (started) begin
      chk("out0",  out0,  m_out[0]);
      chk("rise0", rise0, m_rise[0]);
      chk("fall0", fall0, m_fall[0]);
      chk("out1",  out1,  m_out[1]);
      chk("rise1", rise1, m_rise[1]);
      chk("fall1", fall1, m_fall[1]);
      chk("rise_and_fall0", rise0 & fall0, '0);
      chk("tick", u_dut0.w_tick, ((m_cyc % TD) == TD - 1) && !rst);
    end
  end

  // Scenario observation of dut0, plus any pulse seen on dut1.
  int first_chg;
  int rises0[NCH], falls0[NCH];
  int both_r, both_f, pulses1, ticks;

  task automatic clear_acc();
    for (int c = 0; c < NCH; c++) begin
      rises0[c] = 0;
      falls0[c] = 0;
    end
    both_r = 0; both_f = 0; pulses1 = 0; ticks = 0;
  endtask

  task automatic run(input int n);
    logic [NCH-1:0] start;
    start     = out0;
    first_chg = -1;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      if (first_chg < 0 && out0 !== start) first_chg = e;
      for (int c = 0; c < NCH; c++) begin
        rises0[c] += int'(rise0[c]);
        falls0[c] += int'(fall0[c]);
      end
      if (rise0 == 2'b11) both_r++;
      if (fall0 == 2'b11) both_f++;
      pulses1 += int'(|rise1) + int'(|fall1);
      ticks   += int'(u_dut0.w_tick);
    end
  endtask

  task automatic drive(input logic [NCH-1:0] v);
    @(negedge clk);
    in = v;
  endtask

  int hold[NCH];
  bit found;

  initial begin
    #2 rst = 1'b1;
    started = 1'b1;
    #1;
    chk("rst_out0",  out0, 2'b00);
    chk("rst_out1",  out1, 2'b11);
    chk("rst_pulse", {rise0, fall0, rise1, fall1}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle: nothing moves and the tick arrives every 4th cycle.
    clear_acc();
    run(40);
    chk("idle_ticks", ticks, 10);
    chk("idle_out0", out0, 2'b00);
    chk("idle_pulses", rises0[0] + rises0[1] + falls0[0] + falls0[1], 0);

    // Clean step on channel 0.
    clear_acc();
    drive(2'b01);
    run(30);
    chk_rng("step_latency", first_chg, 11, 14);
    chk("step_rise_cnt", rises0[0], 1);
    chk("step_other", {out0[1], 8'(falls0[0] + falls0[1] + rises0[1])}, '0);
    drive(2'b00);
    run(30);

    // Bounce: 6 cycles high, 2 low, then steady high.
    clear_acc();
    drive(2'b01); run(6);
    drive(2'b00); run(2);
    chk("bounce_no_early", out0[0], 1'b0);
    drive(2'b01);
    run(30);
    chk_rng("bounce_latency", first_chg, 1, 14);
    chk("bounce_rise_cnt", rises0[0], 1);
    drive(2'b00);
    run(30);

    // One-tick pulses, 20 times: the count restarts and never matures.
    clear_acc();
    for (int i = 0; i < 20; i++) begin
      drive(2'b01); run(TD);
      drive(2'b00); run(TD);
    end
    run(20);
    chk("glitch_out0", out0[0], 1'b0);
    chk("glitch_pulses", rises0[0] + falls0[0], 0);

    // Both channels move together.
    clear_acc();
    drive(2'b11); run(30);
    chk("simul_rise", both_r, 1);
    chk("simul_out", out0, 2'b11);
    drive(2'b00); run(30);
    chk("simul_fall", both_f, 1);
    chk("simul_rise_cnt", rises0[0] + rises0[1], 2);

    // Async reset mid-count, with out0=11 heading back down.
    drive(2'b11); run(30);
    drive(2'b00);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      found = (m_run[0][0] == 2);
    end
    chk("midcount_reached", found, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_out0", out0, 2'b00);
    chk("arst_out1", out1, 2'b11);
    drive(2'b11);
    @(negedge clk);
    rst = 1'b0;
    clear_acc();
    run(30);
    chk_rng("release_latency", first_chg, 11, 14);
    chk("release_out0", out0, 2'b11);
    chk("rv1_no_pulses", pulses1, 0);
    chk("rv1_out", out1, 2'b11);

    // Random phase. Holds are a mix of short glitches and long steady runs.
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          in[c]   = ~in[c];
          hold[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : $urandom_range(10, 30);
        end else begin
          hold[c]--;
        end
      end
      if (i == 1500) begin
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
